ctrl_out_stretch: RTL and testbench



---
 rtl/ctrl_out_stretch_if.sv | 21 ++
 rtl/ctrl_out_stretch.sv | 162 ++++++++++++++++
 tb/tb_ctrl_out_stretch.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ctrl_out_stretch_if.sv
// ctrl_out_stretch_if: bundles the control register, the multiplexer bits and
// the conditioned outputs of the ctrl_out_stretch block.
//   ctrl  : mode register, bits [2*ch+1:2*ch] select the mode of channel ch
//   in    : per-channel multiplexer outputs
//   clear : per-channel latch clear pulses
//   out   : per-channel conditioned outputs (registered)
//   busy  : per-channel "not IDLE" flags (registered)
// master drives ctrl/in/clear, slave (the block) drives out/busy.
interface ctrl_out_stretch_if #(
  parameter int NUM_CH    = 3,
  parameter int REG_WIDTH = 32
);
  logic [REG_WIDTH-1:0] ctrl;
  logic [NUM_CH-1:0]    in;
  logic [NUM_CH-1:0]    clear;
  logic [NUM_CH-1:0]    out;
  logic [NUM_CH-1:0]    busy;

  modport master (output ctrl, in, clear, input out, busy);
  modport slave  (input ctrl, in, clear, output out, busy);
endinterface

// File: rtl/ctrl_out_stretch.sv
// ctrl_out_stretch: per-channel pulse stretcher / blinker / latch that sits
// between the control-output multiplexer and the pins.
//   clock   : system clock, all state on the rising edge
//   reset_n : synchronous active-low reset
//   bus     : ctrl/in/clear in, out/busy out (see ctrl_out_stretch_if)
// Modes per channel: 00 BYPASS, 01 STRETCH, 10 BLINK, 11 LATCH.
// Every output is registered: out(t+1) = f(in(t), state(t)).

// One channel. Registers: state, out, busy, scnt, bcnt, mode_q.
module ctrl_out_stretch_ch #(
  parameter int CNT_BITS       = 24,
  parameter int STRETCH_CYCLES = 10000000,
  parameter int BLINK_CYCLES   = 2500000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] mode,
  input  logic       in,
  input  logic       clear,
  output logic       out,
  output logic       busy
);
  localparam logic [1:0] M_BYPASS  = 2'b00;
  localparam logic [1:0] M_STRETCH = 2'b01;
  localparam logic [1:0] M_BLINK   = 2'b10;
  localparam logic [1:0] M_LATCH   = 2'b11;

  localparam logic [CNT_BITS-1:0] S_LOAD = CNT_BITS'(STRETCH_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] B_LOAD = CNT_BITS'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_LATCH} st_t;

  st_t                 state, state_nxt;
  logic [CNT_BITS-1:0] scnt, scnt_nxt;
  logic [CNT_BITS-1:0] bcnt, bcnt_nxt;
  logic [1:0]          mode_q;
  logic                out_nxt;
  logic                mode_chg;

  // A mode change resets the channel and is the highest-priority rule.
  assign mode_chg = (mode != mode_q);

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      scnt   <= '0;
      bcnt   <= '0;
      mode_q <= M_BYPASS;
      out    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      scnt   <= scnt_nxt;
      bcnt   <= bcnt_nxt;
      mode_q <= mode;
      out    <= out_nxt;
      busy   <= (state_nxt != ST_IDLE);
    end
  end

  // Next state and counters
  always_comb begin
    state_nxt = state;
    scnt_nxt  = scnt;
    bcnt_nxt  = bcnt;
    if (mode_chg) begin
      state_nxt = ST_IDLE;
      scnt_nxt  = '0;
      bcnt_nxt  = '0;
    end else begin
      case (mode_q)
        M_STRETCH, M_BLINK: begin
          case (state)
            ST_IDLE: begin
              if (in) begin
                state_nxt = ST_HOLD;
                scnt_nxt  = S_LOAD;
                bcnt_nxt  = (mode_q == M_BLINK) ? B_LOAD : '0;
              end
            end
            ST_HOLD: begin
              if (!in && scnt == '0) begin
                // Expiry beats a blink toggle due in the same cycle.
                state_nxt = ST_IDLE;
                bcnt_nxt  = '0;
              end else begin
                scnt_nxt = in ? S_LOAD : scnt - 1'b1;
                // Retrigger only reloads scnt; the blink phase keeps running.
                if (mode_q == M_BLINK)
                  bcnt_nxt = (bcnt == '0) ? B_LOAD : bcnt - 1'b1;
              end
            end
            default: state_nxt = ST_IDLE;
          endcase
        end
        M_LATCH: begin
          case (state)
            ST_IDLE:  if (in)    state_nxt = ST_LATCH;
            ST_LATCH: if (clear) state_nxt = ST_IDLE;
            default:             state_nxt = ST_IDLE;
          endcase
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output
  always_comb begin
    out_nxt = 1'b0;
    if (!mode_chg) begin
      case (mode_q)
        M_BYPASS:  out_nxt = in;
        M_STRETCH: out_nxt = (state_nxt == ST_HOLD);
        M_BLINK: begin
          if (state_nxt == ST_HOLD)
            out_nxt = (state != ST_HOLD) ? 1'b1 : ((bcnt == '0) ? ~out : out);
        end
        default:   out_nxt = (state_nxt == ST_LATCH);
      endcase
    end
  end
endmodule

module ctrl_out_stretch #(
  parameter int NUM_CH         = 3,
  parameter int REG_WIDTH      = 32,
  parameter int CNT_BITS       = 24,
  parameter int STRETCH_CYCLES = 10000000,
  parameter int BLINK_CYCLES   = 2500000
) (
  input  logic               clock,
  input  logic               reset_n,
  ctrl_out_stretch_if.slave  bus
);
  logic [NUM_CH-1:0] out_w;
  logic [NUM_CH-1:0] busy_w;
  logic              ctrl_unused;

  // Bits of ctrl above the mode fields are deliberately ignored.
  assign ctrl_unused = ^bus.ctrl;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    ctrl_out_stretch_ch #(
      .CNT_BITS       (CNT_BITS),
      .STRETCH_CYCLES (STRETCH_CYCLES),
      .BLINK_CYCLES   (BLINK_CYCLES)
    ) u_ch (
      .clock   (clock),
      .reset_n (reset_n),
      .mode    (bus.ctrl[2*ch+1 -: 2]),
      .in      (bus.in[ch]),
      .clear   (bus.clear[ch]),
      .out     (out_w[ch]),
      .busy    (busy_w[ch])
    );
  end

  assign bus.out  = out_w;
  assign bus.busy = busy_w;
endmodule

// File: tb/tb_ctrl_out_stretch.sv
module tb_ctrl_out_stretch;
  localparam int NUM_CH = 3, REG_WIDTH = 32, CNT_BITS = 8, S = 8, B = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  ctrl_out_stretch_if #(.NUM_CH(NUM_CH), .REG_WIDTH(REG_WIDTH)) bus();

  ctrl_out_stretch #(
    .NUM_CH(NUM_CH), .REG_WIDTH(REG_WIDTH), .CNT_BITS(CNT_BITS),
    .STRETCH_CYCLES(S), .BLINK_CYCLES(B)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0, cyc = 0;

  // Reference model: stretch/blink on-time is "within S cycles of the last
  // high input since the mode became active"; blink phase is derived from the
  // entry cycle by division; latch is a set/clear flag.
  logic [1:0] m_mode [NUM_CH];
  bit         m_act  [NUM_CH];
  bit         m_lat  [NUM_CH];
  int         m_last [NUM_CH];
  int         m_ent  [NUM_CH];
  logic [NUM_CH-1:0] exp_out = '0, exp_busy = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      logic [1:0] m;
      m = bus.ctrl[2*ch +: 2];
      if (!reset_n) begin
        m_mode[ch] = 2'b00; m_act[ch] = 0; m_lat[ch] = 0;
        exp_out[ch] = 0; exp_busy[ch] = 0;
      end else if (m != m_mode[ch]) begin
        m_mode[ch] = m; m_act[ch] = 0; m_lat[ch] = 0;
        exp_out[ch] = 0; exp_busy[ch] = 0;
      end else begin
        case (m)
          2'b00: begin exp_out[ch] = bus.in[ch]; exp_busy[ch] = 0; end
          2'b01, 2'b10: begin
            if (bus.in[ch]) begin
              if (!m_act[ch]) m_ent[ch] = cyc;
              m_act[ch] = 1; m_last[ch] = cyc;
            end else if (m_act[ch]) begin
              m_act[ch] = (cyc - m_last[ch]) < S;
            end
            exp_out[ch]  = m_act[ch] && (m == 2'b01 || ((cyc - m_ent[ch]) / B) % 2 == 0);
            exp_busy[ch] = m_act[ch];
          end
          default: begin
            if (m_lat[ch] && bus.clear[ch]) m_lat[ch] = 0;
            else if (!m_lat[ch] && bus.in[ch]) m_lat[ch] = 1;
            exp_out[ch] = m_lat[ch]; exp_busy[ch] = m_lat[ch];
          end
        endcase
      end
    end
    cyc++;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    chk("out", 32'(bus.out), 32'(exp_out));
    chk("busy", 32'(bus.busy), 32'(exp_busy));
  endtask

  task automatic run(input logic [REG_WIDTH-1:0] c, input logic [NUM_CH-1:0] i,
                     input logic [NUM_CH-1:0] cl);
    bus.ctrl = c; bus.in = i; bus.clear = cl;
    step();
  endtask

  initial begin
    int cnt;
    logic [8:0] pat;
    logic prev_in0;
    logic [REG_WIDTH-1:0] c;
    logic [NUM_CH-1:0] rin, rcl;

    bus.ctrl = 32'h15; bus.in = '1; bus.clear = '0;

    // Reset with all channels in STRETCH and inputs high
    repeat (3) begin
      step();
      chk("rst_out", 32'(bus.out), 0);
      chk("rst_busy", 32'(bus.busy), 0);
    end
    reset_n = 1'b1;
    repeat (4) run(32'h15, '1, '0);
    chk("post_rst_out", 32'(bus.out), 32'h7);
    repeat (12) run(32'h15, '0, '0);

    // STRETCH single pulse: exactly S high cycles
    cnt = 0;
    run(32'h15, 3'b001, '0); cnt += bus.out[0];
    repeat (11) begin run(32'h15, '0, '0); cnt += bus.out[0]; end
    chk("str_width", cnt, S);

    // STRETCH retrigger 5 cycles later: 13 high cycles
    cnt = 0;
    run(32'h15, 3'b001, '0); cnt += bus.out[0];
    repeat (4) begin run(32'h15, '0, '0); cnt += bus.out[0]; end
    run(32'h15, 3'b001, '0); cnt += bus.out[0];
    repeat (14) begin run(32'h15, '0, '0); cnt += bus.out[0]; end
    chk("str_retrig", cnt, 13);

    // BLINK on ch0: 1111 0000 then idle
    repeat (3) run(32'h16, '0, '0);
    pat = '0;
    run(32'h16, 3'b001, '0); pat = {pat[7:0], bus.out[0]};
    repeat (8) begin run(32'h16, '0, '0); pat = {pat[7:0], bus.out[0]}; end
    chk("blink_pat", 32'(pat), 32'h1E0);
    chk("blink_idle", 32'(bus.busy[0]), 0);
    repeat (20) run(32'h16, 3'b001, '0);
    repeat (12) run(32'h16, '0, '0);

    // LATCH on ch2: clear with in high relatches next cycle
    repeat (2) run(32'h36, '0, '0);
    run(32'h36, 3'b100, '0);
    repeat (14) run(32'h36, '0, '0);
    chk("latch_held", 32'(bus.out[2]), 1);
    run(32'h36, 3'b100, 3'b100);
    chk("latch_clr", 32'(bus.out[2]), 0);
    run(32'h36, 3'b100, '0);
    chk("latch_relatch", 32'(bus.out[2]), 1);
    run(32'h36, '0, 3'b100);
    repeat (3) run(32'h36, '0, '0);
    chk("latch_cleared", 32'(bus.out[2]), 0);

    // Mode change ch1 STRETCH -> BYPASS mid-hold
    run(32'h36, 3'b010, '0);
    repeat (2) run(32'h36, '0, '0);
    run(32'h32, '0, '0);
    chk("mchg_out", 32'(bus.out[1]), 0);
    chk("mchg_busy", 32'(bus.busy[1]), 0);
    run(32'h32, 3'b010, '0);
    chk("mchg_byp", 32'(bus.out[1]), 1);

    // ch0 BYPASS, ch1 STRETCH, random inputs
    repeat (300) begin
      prev_in0 = 1'($urandom_range(0, 1));
      run(32'h34, {1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0), prev_in0}, '0);
      chk("byp_ch0", 32'(bus.out[0]), 32'(prev_in0));
    end

    // Fully random: modes, sparse pulses, clears, occasional reset
    c = 32'h36;
    repeat (3000) begin
      if ($urandom_range(0, 39) == 0) c = $urandom();
      rin = '0; rcl = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        rin[ch] = ($urandom_range(0, 7) == 0);
        rcl[ch] = ($urandom_range(0, 9) == 0);
      end
      reset_n = ($urandom_range(0, 499) != 0);
      run(c, rin, rcl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
